uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART TX FIFO write port between two first-word-fall-through byte sources:
//  the SPI slave RX FIFO and the UART RX FIFO (echo path).
//  Replaces ad-hoc per-source echo logic: only one source writes per strobe, so bytes are never lost.
//  Sits in the top level between spi_slave/uart FIFO status ports and the uart TX FIFO write port.
//  Keeps per-source byte counters for debug.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles after a pop during which source empty flags are ignored; must be >= 1
//  PRIORITY_MODE  0   0 = round-robin between SPI and UART; 1 = fixed priority, SPI wins
//  COUNT_WIDTH    16  width of each per-source byte counter
// PORTS
//  clock              in   1            system clock, 27 MHz
//  reset              in   1            synchronous, active-high
//  spi_fifo_empty     in   1            SPI RX FIFO empty
//  spi_fifo_data_out  in   8            SPI RX FIFO head byte; valid when !empty
//  spi_fifo_read_en   out  1            one-cycle pop strobe to the SPI RX FIFO
//  rx_fifo_empty      in   1            UART RX FIFO empty
//  rx_fifo_data_out   in   8            UART RX FIFO head byte; valid when !empty
//  rx_fifo_read_en    out  1            one-cycle pop strobe to the UART RX FIFO
//  tx_fifo_full       in   1            UART TX FIFO full; blocks new grants
//  tx_fifo_write_en   out  1            one-cycle push strobe to the UART TX FIFO
//  tx_fifo_data_in    out  8            byte pushed to the UART TX FIFO
//  grant              out  2            one-hot owner; [0] = SPI, [1] = UART; 0 when idle
//  busy               out  1            1 while state != IDLE
//  spi_byte_count     out  COUNT_WIDTH  bytes forwarded from SPI; saturating
//  uart_byte_count    out  COUNT_WIDTH  bytes forwarded from UART RX; saturating
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: all outputs 0, state IDLE, last_grant = UART (so the first tie goes to SPI).
//  - Reset mid-operation: every strobe drops on the same edge; counters clear; no partial transfer.
//  - States: IDLE, SETTLE.
//  - IDLE: req_spi = !spi_fifo_empty, req_uart = !rx_fifo_empty. No grant while tx_fifo_full = 1.
//  - On an IDLE edge with at least one request and !tx_fifo_full:
//    - Select a source:
//      - single request -> that source;
//      - both, PRIORITY_MODE=0 -> the source != last_grant;
//      - both, PRIORITY_MODE=1 -> SPI.
//    - Same edge: tx_fifo_data_in <= selected data_out; tx_fifo_write_en <= 1.
//    - Same edge: selected read_en <= 1; grant <= one-hot; last_grant <= selected.
//    - Same edge: selected count += 1 (held at all-ones when already saturated); state <= SETTLE; cnt <= SETTLE_CYCLES-1.
//  - SETTLE:
//    - Strobes are low; grant holds.
//    - Empty flags and tx_fifo_full are ignored.
//    - When cnt == 0: state <= IDLE, grant <= 0. Otherwise cnt -= 1.
//  - Timing: a request seen at edge E gives a write/read pulse during cycle E..E+1 (latency 1).
//  - Minimum strobe period is SETTLE_CYCLES+1 cycles.
//  - Exactly one read_en and one write_en pulse per byte; they are always coincident.
//  - read_en is never asserted toward an unselected source.
//  - tx_fifo_data_in holds its last value between strobes.
//  - A source that empties during SETTLE is simply not requesting in IDLE; no special handling.
//  - tx_fifo_full rising during SETTLE does not cancel the pulse already issued; only the next grant waits.
// TESTING
//  - SPI holds 0x41,0x42,0x43, UART RX empty, SETTLE_CYCLES=2
//    -> 3 write pulses 3 cycles apart, data 41,42,43;
//    -> spi_fifo_read_en coincident each time; spi_byte_count=3.
//  - Both sources always non-empty, PRIORITY_MODE=0, right after reset
//    -> grant sequence SPI,UART,SPI,UART; data alternates correctly.
//  - Both sources hold 3 bytes each, PRIORITY_MODE=1
//    -> all 3 SPI bytes written first, then 3 UART bytes; counts 3/3.
//  - tx_fifo_full=1 for 50 cycles with both sources pending
//    -> no strobes, busy=0; full drops at edge E -> write pulse at edge E+1.
//  - reset pulsed during SETTLE
//    -> next edge: busy=0, grant=0, counts=0; subsequent tie grants SPI first.
//  - COUNT_WIDTH=4, 20 UART bytes
//    -> 20 write pulses; uart_byte_count saturates at 15.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the UART TX FIFO write port between the SPI RX and UART RX FWFT byte sources,
// one registered pop/push pair per grant, with saturating per-source byte counters.
module uart_tx_arbiter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PRIORITY_MODE = 0,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   spi_fifo_empty,
   input  logic [7:0]             spi_fifo_data_out,
   output logic                   spi_fifo_read_en,
   input  logic                   rx_fifo_empty,
   input  logic [7:0]             rx_fifo_data_out,
   output logic                   rx_fifo_read_en,
   input  logic                   tx_fifo_full,
   output logic                   tx_fifo_write_en,
   output logic [7:0]             tx_fifo_data_in,
   output logic [1:0]             grant,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] spi_byte_count,
   output logic [COUNT_WIDTH-1:0] uart_byte_count
);
   localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
   typedef enum logic {IDLE, SETTLE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic last_uart, last_uart_n;
   logic req_spi, req_uart, take, pick_spi;
   logic spi_rd_n, rx_rd_n;
   logic [7:0] data_n;
   logic [1:0] grant_n;
   logic [COUNT_WIDTH-1:0] spi_cnt_n, uart_cnt_n;
   assign req_spi  = !spi_fifo_empty;
   assign req_uart = !rx_fifo_empty;
   assign take     = state == IDLE && (req_spi || req_uart) && !tx_fifo_full;
   // last_uart set means UART won the previous grant, so SPI wins the next tie
   assign pick_spi = req_spi && (!req_uart || PRIORITY_MODE == 1 || last_uart);
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      grant_n     = grant;
      last_uart_n = last_uart;
      spi_rd_n    = 1'b0;
      rx_rd_n     = 1'b0;
      data_n      = tx_fifo_data_in;
      spi_cnt_n   = spi_byte_count;
      uart_cnt_n  = uart_byte_count;
      if (take) begin
         state_n     = SETTLE;
         cnt_n       = CNT_INIT;
         grant_n     = pick_spi ? 2'b01 : 2'b10;
         last_uart_n = !pick_spi;
         spi_rd_n    = pick_spi;
         rx_rd_n     = !pick_spi;
         data_n      = pick_spi ? spi_fifo_data_out : rx_fifo_data_out;
         spi_cnt_n   = (pick_spi && !(&spi_byte_count)) ? spi_byte_count + 1'b1 : spi_byte_count;
         uart_cnt_n  = (!pick_spi && !(&uart_byte_count)) ? uart_byte_count + 1'b1 : uart_byte_count;
      end else if (state == SETTLE) begin
         if (cnt == '0) begin
            state_n = IDLE;
            grant_n = 2'b00;
         end else begin
            cnt_n = cnt - 1'b1;
         end
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         last_uart        <= 1'b1;
         grant            <= 2'b00;
         busy             <= 1'b0;
         spi_fifo_read_en <= 1'b0;
         rx_fifo_read_en  <= 1'b0;
         tx_fifo_write_en <= 1'b0;
         tx_fifo_data_in  <= 8'h00;
         spi_byte_count   <= '0;
         uart_byte_count  <= '0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         last_uart        <= last_uart_n;
         grant            <= grant_n;
         busy             <= state_n == SETTLE;
         spi_fifo_read_en <= spi_rd_n;
         rx_fifo_read_en  <= rx_rd_n;
         tx_fifo_write_en <= take;
         tx_fifo_data_in  <= data_n;
         spi_byte_count   <= spi_cnt_n;
         uart_byte_count  <= uart_cnt_n;
      end
   end
endmodule
